// File: rtl/add8_serial_ctrl_pkg.sv
// Shared types and default sizing for the serial adder sequencer.
package add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_DEF = 2;
  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/add8_serial_ctrl_adder_slice.sv
// Combinational W-bit adder slice reused every cycle by the serial sequencer.
module adder_slice #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/add8_serial_ctrl.sv
// Serial WIDTH-bit adder: one SLICE-bit slice per cycle, LSB slice first, carry registered.
//  state | meaning
//  IDLE  | in_ready high, waiting for operands
//  RUN   | adding one slice per edge, count tracks the slice index
//  DONE  | out_valid high, result held until out_ready
module add8_serial_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("add8_serial_ctrl: WIDTH must be a multiple of SLICE");
  end

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [SLICE-1:0] sl_s;
  logic             sl_co;

  adder_slice #(.W(SLICE)) u_slice (
    .a  (a_sh[SLICE-1:0]),
    .b  (b_sh[SLICE-1:0]),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (count == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Slice results enter sum_sh at the MSB end, so after NSLICE edges slice 0 sits at the LSBs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> SLICE;
          b_sh   <= b_sh >> SLICE;
          sum_sh <= {sl_s, sum_sh[WIDTH-1:SLICE]};
          carry  <= sl_co;
          if (count != LAST) count <= count + CW'(1);
          else               count <= '0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_sh;
  assign cout      = carry;

endmodule

// File: tb/tb_add8_serial_ctrl.sv
// Scoreboard bench for add8_serial_ctrl: driver pushes a+b+cin, monitor pops on each output handshake.
module tb_add8_serial_ctrl;

  localparam int NSLICE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;

  always #5 clk = ~clk;

  add8_serial_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  typedef struct {
    logic [8:0] res;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  bit   track_gap = 1'b0;
  int   last_acc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: out_ready policy plus result/latency checks against the scoreboard.
  initial begin : monitor
    logic prev_v;
    prev_v = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h expected=none (cycle %0d)", {cout, sum}, cyc);
        end else begin
          if (!prev_v) chk("latency", cyc - sb[0].acc, NSLICE);
          if (out_ready) begin
            exp_t e;
            e = sb.pop_front();
            chk("result", {23'd0, cout, sum}, {23'd0, e.res});
          end
        end
      end
      prev_v = out_valid && !out_ready;
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c, input bit keep);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    a = x; b = y; cin = c; in_valid = 1'b1;
    while (!in_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low expected=accept (cycle %0d)", cyc);
      in_valid = 1'b0;
      return;
    end
    e.res = {1'b0, x} + {1'b0, y} + {8'd0, c};
    e.acc = cyc + 1;
    if (track_gap && last_acc >= 0) chk("accept_gap", e.acc - last_acc, NSLICE + 2);
    last_acc = e.acc;
    sb.push_back(e);
    if (!keep) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending results", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);

    // Directed corner operands.
    ready_mode = 0;
    send(8'h00, 8'h00, 1'b0, 1'b0); drain();
    send(8'hFF, 8'h01, 1'b0, 1'b0); drain();
    send(8'hA5, 8'h5A, 1'b1, 1'b0); drain();
    send(8'h03, 8'h03, 1'b0, 1'b0); drain();
    send(8'hFF, 8'hFF, 1'b1, 1'b0); drain();

    // Backpressure: result held, competing operand ignored.
    ready_mode = 2;
    send(8'hC3, 8'h4D, 1'b1, 1'b0);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("bp_reached_done", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result", {23'd0, cout, sum}, 32'h111);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    ready_mode = 0;
    drain();
    chk("bp_no_extra", out_valid, 0);

    // Reset mid-RUN at count==2 discards the operation.
    send(8'h12, 8'h34, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    chk("rst_run_in_ready", in_ready, 1);
    chk("rst_run_out_valid", out_valid, 0);
    chk("rst_run_sum", sum, 0);
    chk("rst_run_cout", cout, 0);
    repeat (6) @(negedge clk);
    chk("rst_run_no_output", out_valid, 0);
    send(8'h10, 8'h20, 1'b0, 1'b0); drain();

    // Back-to-back with in_valid held: accepts exactly NSLICE+2 apart.
    ready_mode = 0;
    track_gap = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 8; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    track_gap = 1'b0;
    drain();

    // Random operands, random gaps and random out_ready.
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
